// File: rtl/alineador_coma.sv
// Receive-side K28.5 comma aligner. It watches the shifter's 10-bit sliding
// window on every bit clock, finds the symbol boundary, and once locked
// strobes one aligned 10-bit symbol per boundary toward the 8b/10b decoder.
module alineador_coma #(
  parameter int COMMAS_LOCK = 2,
  parameter int ERR_UNLOCK  = 4
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic [9:0] IP,
  output logic [9:0] SYM,
  output logic       VALID,
  output logic       K_COM,
  output logic       LOCK
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  localparam logic [3:0] CL = 4'(COMMAS_LOCK);
  localparam logic [3:0] EU = 4'(ERR_UNLOCK);

  state_t     st_q;
  logic [3:0] ph_q, cnt_q, miss_q;
  logic [9:0] sym_q;
  logic       vld_q, k_q, lock_q;

  logic       comma, bnd;
  logic [3:0] ph_inc, cnt_inc, miss_inc;

  // Both running disparities of K28.5 are accepted.
  assign comma    = (IP == 10'h17C) || (IP == 10'h283);
  assign bnd      = (ph_q == 4'd0);
  assign ph_inc   = (ph_q == 4'd9) ? 4'd0 : ph_q + 4'd1;
  assign cnt_inc  = cnt_q + 4'd1;
  assign miss_inc = miss_q + 4'd1;

  // Alignment FSM with phase counter, comma/miss counters and registered outputs.
  // A reload sets PH to 1 so the next boundary falls exactly 10 bits after the comma.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      st_q   <= HUNT;
      ph_q   <= 4'd0;
      cnt_q  <= 4'd0;
      miss_q <= 4'd0;
      sym_q  <= 10'd0;
      vld_q  <= 1'b0;
      k_q    <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      ph_q  <= ph_inc;
      vld_q <= 1'b0;
      k_q   <= 1'b0;
      case (st_q)
        HUNT: begin
          if (comma) begin
            ph_q  <= 4'd1;
            cnt_q <= 4'd1;
            if (CL == 4'd1) begin
              // Single-comma lock: this comma is the lock-completing one.
              st_q   <= LOCKED;
              lock_q <= 1'b1;
              sym_q  <= IP;
              vld_q  <= 1'b1;
              k_q    <= 1'b1;
            end else begin
              st_q <= CHECK;
            end
          end
        end
        CHECK: begin
          if (comma) begin
            if (bnd) begin
              cnt_q <= cnt_inc;
              if (cnt_inc == CL) begin
                st_q   <= LOCKED;
                lock_q <= 1'b1;
                sym_q  <= IP;
                vld_q  <= 1'b1;
                k_q    <= 1'b1;
              end
            end else begin
              // Comma on a new phase: start counting again from here.
              ph_q  <= 4'd1;
              cnt_q <= 4'd1;
            end
          end
        end
        LOCKED: begin
          if (bnd) begin
            sym_q <= IP;
            vld_q <= 1'b1;
            k_q   <= comma;
            if (comma) miss_q <= 4'd0;
          end else if (comma) begin
            // Misphased comma: phase is kept, only the miss count moves.
            if (miss_inc == EU) begin
              st_q   <= HUNT;
              lock_q <= 1'b0;
              cnt_q  <= 4'd0;
              miss_q <= 4'd0;
            end else begin
              miss_q <= miss_inc;
            end
          end
        end
        default: begin
          st_q   <= HUNT;
          lock_q <= 1'b0;
        end
      endcase
    end
  end

  assign SYM   = sym_q;
  assign VALID = vld_q;
  assign K_COM = k_q;
  assign LOCK  = lock_q;

endmodule

// File: tb/tb_alineador_coma.sv
// Bench for alineador_coma: two instances (COMMAS_LOCK 2 and 3, ERR_UNLOCK 4)
// share a bench-side serial shifter; a boundary-arithmetic reference model
// predicts every output of both instances on every bit.
module tb_alineador_coma;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ip = 10'd0;
  logic [9:0] win = 10'd0;

  logic [9:0] sa, sb;
  logic       va, ka, la, vb, kb, lb;

  alineador_coma #(.COMMAS_LOCK(2), .ERR_UNLOCK(4)) dut_a (
    .CLOCK(clk), .RESET_N(rst_n), .IP(ip),
    .SYM(sa), .VALID(va), .K_COM(ka), .LOCK(la));

  alineador_coma #(.COMMAS_LOCK(3), .ERR_UNLOCK(4)) dut_b (
    .CLOCK(clk), .RESET_N(rst_n), .IP(ip),
    .SYM(sb), .VALID(vb), .K_COM(kb), .LOCK(lb));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: a boundary is any bit time that is a multiple of 10
  // after the last anchor (reset release or re-anchoring comma).
  int         t = 0;
  int         cl_m[2] = '{2, 3};
  int         st_m[2];      // 0 hunt, 1 check, 2 locked
  int         anc[2];
  int         cnt_m[2];
  int         miss_m[2];
  logic [9:0] esym[2];
  logic       evld[2], ek[2], elk[2];

  int          mm = 0;
  int          mm_t = 0;
  logic [25:0] mm_o, mm_e;

  function automatic void mstep(int k, logic [9:0] v, logic rn);
    bit cm, bd;
    if (!rn) begin
      st_m[k] = 0; anc[k] = t + 1; cnt_m[k] = 0; miss_m[k] = 0;
      esym[k] = 10'd0; evld[k] = 1'b0; ek[k] = 1'b0; elk[k] = 1'b0;
      return;
    end
    cm = (v == 10'h17C) || (v == 10'h283);
    bd = ((t - anc[k]) % 10) == 0;
    evld[k] = 1'b0;
    ek[k]   = 1'b0;
    case (st_m[k])
      0: if (cm) begin
        anc[k] = t; cnt_m[k] = 1;
        if (cl_m[k] == 1) begin
          st_m[k] = 2; esym[k] = v; evld[k] = 1'b1; ek[k] = 1'b1;
        end else st_m[k] = 1;
      end
      1: if (cm) begin
        if (bd) begin
          cnt_m[k]++;
          if (cnt_m[k] == cl_m[k]) begin
            st_m[k] = 2; esym[k] = v; evld[k] = 1'b1; ek[k] = 1'b1;
          end
        end else begin
          anc[k] = t; cnt_m[k] = 1;
        end
      end
      default: begin
        if (bd) begin
          esym[k] = v; evld[k] = 1'b1; ek[k] = cm;
          if (cm) miss_m[k] = 0;
        end else if (cm) begin
          miss_m[k]++;
          if (miss_m[k] == 4) begin
            st_m[k] = 0; cnt_m[k] = 0; miss_m[k] = 0;
          end
        end
      end
    endcase
    elk[k] = (st_m[k] == 2);
  endfunction

  // Drive one window value, clock it, advance the model and log divergence.
  task automatic tick_raw(input logic [9:0] v);
    logic [25:0] o, e;
    ip = v;
    @(posedge clk);
    mstep(0, v, rst_n);
    mstep(1, v, rst_n);
    t++;
    #1;
    o = {sa, va, ka, la, sb, vb, kb, lb};
    e = {esym[0], evld[0], ek[0], elk[0], esym[1], evld[1], ek[1], elk[1]};
    if (o !== e) begin
      if (mm == 0) begin mm_t = t; mm_o = o; mm_e = e; end
      mm++;
    end
  endtask

  // Shift one new bit into the window (newest bit lands in IP[9]).
  task automatic tick(input logic b);
    win = {b, win[9:1]};
    tick_raw(win);
  endtask

  task automatic send(input logic [9:0] s);
    for (int i = 0; i < 10; i++) tick(s[i]);
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) tick(1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mm = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      win = (i % 2 == 1) ? 10'h283 : 10'h17C;
      tick_raw(win);
      total++;
      if ({sa, va, ka, la, sb, vb, kb, lb} !== 26'd0) begin
        $display("FAIL reset_hold[%0d]: got %h expected 0", i, {sa, va, ka, la, sb, vb, kb, lb});
      end else passed++;
    end
    rst_n = 1'b1;
    win = 10'd0;
    zeros(25);
    total++;
    if ({va, la, vb, lb} !== 4'b0000) begin
      $display("FAIL hunt_idle: got va/la/vb/lb=%b expected 0000", {va, la, vb, lb});
    end else passed++;
    total++;
    if (mm !== 0) begin
      $display("FAIL model_reset: %0d mismatches, first cycle %0d got %h expected %h", mm, mm_t, mm_o, mm_e);
    end else passed++;
  endtask

  task automatic test_lock();
    mm = 0;
    zeros(3);
    send(10'h17C);
    total++;
    if ({va, la} !== 2'b00) begin
      $display("FAIL first_comma: got valid/lock=%b expected 00", {va, la});
    end else passed++;
    send(10'h155);
    send(10'h283);
    total++;
    if ({va, la, ka, sa} !== {3'b111, 10'h283}) begin
      $display("FAIL lock_comma: got v/l/k=%b sym=%h expected 111 sym=283", {va, la, ka}, sa);
    end else passed++;
    total++;
    if (lb !== 1'b0) begin
      $display("FAIL lock3_early: got lock=%b expected 0", lb);
    end else passed++;
    total++;
    if (mm !== 0) begin
      $display("FAIL model_lock: %0d mismatches, first cycle %0d got %h expected %h", mm, mm_t, mm_o, mm_e);
    end else passed++;
  endtask

  task automatic test_stream();
    logic [9:0] syms[4] = '{10'h155, 10'h17C, 10'h2AA, 10'h0F3};
    int vc;
    mm = 0;
    for (int s = 0; s < 4; s++) begin
      vc = 0;
      for (int b = 0; b < 10; b++) begin
        tick(syms[s][b]);
        if (va === 1'b1) vc++;
      end
      total++;
      if (vc !== 1 || va !== 1'b1 || sa !== syms[s] || ka !== (syms[s] == 10'h17C)) begin
        $display("FAIL stream[%0d]: got valids=%0d v=%b sym=%h k=%b expected valids=1 v=1 sym=%h k=%b",
                 s, vc, va, sa, ka, syms[s], syms[s] == 10'h17C);
      end else passed++;
    end
    total++;
    if (mm !== 0) begin
      $display("FAIL model_stream: %0d mismatches, first cycle %0d got %h expected %h", mm, mm_t, mm_o, mm_e);
    end else passed++;
  endtask

  task automatic test_check_realign();
    mm = 0;
    do_reset();
    zeros(5);
    send(10'h17C);
    zeros(4);
    send(10'h17C);
    send(10'h17C);
    total++;
    if (lb !== 1'b0 || la !== 1'b1) begin
      $display("FAIL realign_cnt2: got lock3=%b lock2=%b expected 0 1", lb, la);
    end else passed++;
    send(10'h17C);
    total++;
    if ({lb, vb, kb, sb} !== {3'b111, 10'h17C}) begin
      $display("FAIL realign_lock: got l/v/k=%b sym=%h expected 111 sym=17c", {lb, vb, kb}, sb);
    end else passed++;
    total++;
    if (mm !== 0) begin
      $display("FAIL model_realign: %0d mismatches, first cycle %0d got %h expected %h", mm, mm_t, mm_o, mm_e);
    end else passed++;
  endtask

  task automatic test_unlock();
    int vc;
    mm = 0;
    do_reset();
    zeros(2);
    send(10'h17C);
    send(10'h17C);
    // Two rounds of three misphased commas, each followed by an aligned one.
    for (int r = 0; r < 2; r++) begin
      zeros(3);
      for (int i = 0; i < 3; i++) send(10'h17C);
      zeros(7);
      send(10'h17C);
      total++;
      if ({la, va, ka} !== 3'b111) begin
        $display("FAIL miss_recover[%0d]: got l/v/k=%b expected 111", r, {la, va, ka});
      end else passed++;
    end
    zeros(3);
    for (int i = 0; i < 3; i++) send(10'h17C);
    total++;
    if (la !== 1'b1) begin
      $display("FAIL miss3_hold: got lock=%b expected 1", la);
    end else passed++;
    send(10'h17C);
    total++;
    if ({la, va} !== 2'b00) begin
      $display("FAIL miss4_drop: got lock/valid=%b expected 00", {la, va});
    end else passed++;
    vc = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      if (va === 1'b1) vc++;
    end
    total++;
    if (vc !== 0) begin
      $display("FAIL valid_after_unlock: got %0d strobes expected 0", vc);
    end else passed++;
    send(10'h17C);
    send(10'h17C);
    total++;
    if ({la, va} !== 2'b11) begin
      $display("FAIL reacquire: got lock/valid=%b expected 11", {la, va});
    end else passed++;
    total++;
    if (mm !== 0) begin
      $display("FAIL model_unlock: %0d mismatches, first cycle %0d got %h expected %h", mm, mm_t, mm_o, mm_e);
    end else passed++;
  endtask

  task automatic test_reset_mid();
    logic [9:0] d = 10'h155;
    mm = 0;
    do_reset();
    zeros(1);
    send(10'h17C);
    send(10'h17C);
    for (int b = 0; b < 9; b++) tick(d[b]);
    rst_n = 1'b0;
    tick(d[9]);
    rst_n = 1'b1;
    total++;
    if ({va, la, sa} !== 12'd0) begin
      $display("FAIL reset_mid: got v/l=%b sym=%h expected 00 sym=000", {va, la}, sa);
    end else passed++;
    zeros(3);
    send(10'h17C);
    send(10'h17C);
    total++;
    if ({la, va, sa} !== {2'b11, 10'h17C}) begin
      $display("FAIL relock: got l/v=%b sym=%h expected 11 sym=17c", {la, va}, sa);
    end else passed++;
    total++;
    if (mm !== 0) begin
      $display("FAIL model_reset_mid: %0d mismatches, first cycle %0d got %h expected %h", mm, mm_t, mm_o, mm_e);
    end else passed++;
  endtask

  task automatic test_random();
    logic [9:0] r;
    mm = 0;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: begin r = 10'($urandom); send(r); end
        1: send(10'h17C);
        2: send(10'h283);
        3: for (int i = $urandom_range(1, 9); i > 0; i--) tick(1'($urandom));
        default: send(10'h155);
      endcase
    end
    total++;
    if (mm !== 0) begin
      $display("FAIL model_random: %0d mismatches, first cycle %0d got %h expected %h", mm, mm_t, mm_o, mm_e);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_stream();
    test_check_realign();
    test_unlock();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alineador_coma.md
# alineador_coma

Receive-side symbol aligner for the PHY. It sits directly downstream of the serial-to-parallel shifter, on the same bit clock, and watches the 10-bit sliding window that shifter produces every bit. It finds K28.5 comma symbols and tracks the 10-bit symbol boundary, declaring lock after repeated aligned commas. Once locked, it emits one aligned 10-bit symbol per boundary with a valid strobe toward the 8b/10b decoder.

## Interface
Parameters:
- COMMAS_LOCK, default 2: number of aligned commas needed to enter LOCKED. Legal range is 1..15.
- ERR_UNLOCK, default 4: number of consecutive misphased commas that drop lock. Legal range is 1..15.

Ports:
- CLOCK  input  1  bit clock, the same clock as the serial-to-parallel shifter. All logic is clocked on its rising edge.
- RESET_N  input  1  reset, synchronous and active-low.
- IP  input  10  sliding window from the shifter. IP[9] is the newest bit and IP[0] the oldest, so the word is LSB-first with bit a in IP[0].
- SYM  output  10  aligned symbol, registered.
- VALID  output  1  one-cycle strobe; SYM is valid while it is high.
- K_COM  output  1  high together with VALID when SYM is a comma.
- LOCK  output  1  high while the FSM is in LOCKED.

## Operation
- Comma match (combinational): IP == 10'h17C (K28.5, RD−) or IP == 10'h283 (K28.5, RD+).
- Phase counter PH, 4 bits, counts 0..9:
  - A boundary exists in any cycle where PH == 0.
  - PH advances by one each cycle and wraps from 9 to 0, unless it is reloaded.
  - Reload PH to 1 on any comma that re-anchors the phase. That makes the next boundary exactly 10 cycles after the comma.
- Counters, 4 bits each:
  - CNT counts aligned commas.
  - MISS counts consecutive misphased commas.
- FSM states are HUNT, CHECK and LOCKED.
- HUNT:
  - Ignore PH.
  - On a comma, reload PH and set CNT = 1. Go to LOCKED if COMMAS_LOCK == 1, otherwise go to CHECK.
- CHECK:
  - Comma on a boundary: CNT++. When CNT reaches COMMAS_LOCK, go to LOCKED.
  - Non-comma on a boundary: no change. Data between commas is allowed.
  - Comma off a boundary: re-anchor by reloading PH, set CNT = 1, and stay in CHECK.
- LOCKED:
  - On every boundary: SYM <= IP, VALID <= 1, K_COM <= comma match.
  - Comma on a boundary: MISS <= 0.
  - Comma off a boundary: MISS++ and PH is not reloaded. When MISS reaches ERR_UNLOCK, go to HUNT, clear CNT and MISS, and generate no VALID that cycle.
- Lock-completing comma: the boundary comma that causes CHECK -> LOCKED is itself output, with VALID = 1 and K_COM = 1.
- VALID is never asserted outside LOCKED, except for the lock-completing comma.
- Reset mid-operation: on the next edge the block returns to the reset state, and any pending SYM is discarded.

## Timing
- Reset values:
  - SYM = 0, VALID = 0, K_COM = 0, LOCK = 0.
  - State = HUNT, PH = 0, CNT = 0, MISS = 0.
- Latency: VALID, SYM and K_COM are high in the cycle after the boundary edge on which IP held the symbol. The latency is 1 clock.
- Strobe spacing: in steady lock, VALID pulses exactly every 10 cycles and is low for the 9 cycles in between.
- LOCK timing:
  - LOCK rises in the same cycle as VALID for the lock-completing comma.
  - LOCK falls one cycle after the edge that samples the ERR_UNLOCK-th misphased comma.
- Boundary priority: a comma on a boundary counts as aligned, never as misphased. When a boundary and a reload coincide (only possible in HUNT), the reload wins.

## Test plan
1. Hold RESET_N = 0 for 3 cycles while IP cycles through commas -> SYM = 0, VALID = 0, K_COM = 0, LOCK = 0 throughout. After release, the block stays in HUNT until the first comma.
2. COMMAS_LOCK = 2. Send a 3-bit offset, then K28.5− (0x17C), D21.5 (0x155) and K28.5+ (0x283), serialized LSB-first -> LOCK and VALID go high with SYM = 0x283 and K_COM = 1, one cycle after the second comma completes. VALID then repeats every 10 cycles.
3. Once locked, stream 0x155, 0x17C, 0x2AA, 0x0F3 -> SYM shows the same sequence, each word one cycle after its boundary. K_COM is high only for 0x17C, and VALID is spaced exactly 10 apart.
4. In CHECK (COMMAS_LOCK = 3), after the first comma insert 4 extra bits before the next comma -> CNT restarts at 1 and LOCK rises only after 2 further aligned commas on the new phase.
5. ERR_UNLOCK = 4:
   - Three consecutive misphased commas followed by an aligned comma -> LOCK stays 1 and MISS returns to 0.
   - Four consecutive misphased commas -> LOCK = 0 one cycle after the fourth, VALID stops, and the FSM reacquires from HUNT.
6. Pull RESET_N low for 1 cycle during LOCKED, with a boundary falling in that cycle -> VALID = 0 and SYM = 0 on the next cycle, and the block relocks normally afterward.
